// File: rtl/numled_scan_driver_pkg.sv
// Shared constants for the NUMLED scan driver: device digit count, scan timing
// defaults and the active-high seven-segment code table ({g,f,e,d,c,b,a}).
package numled_scan_driver_pkg;

  localparam int DEVICE_NUM_NUMLED_EN = 8;
  localparam int SCAN_DIV_DEFAULT     = 100000;
  localparam int GUARD_DEFAULT        = 2;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/numled_scan_driver_hex_decode.sv
// Combinational hex nibble to active-low seven-segment decode.
module numled_hex_decode
  import numled_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = ~SEG_CODE[nibble];

endmodule

// File: rtl/numled_scan_driver.sv
// Eight-digit seven-segment scan driver with frame-aligned shadow loading.
// Optional leading-zero blanking is built when NUMLED_LEADING_ZERO_BLANK_EN is defined.
module numled_scan_driver
  import numled_scan_driver_pkg::*;
#(
  parameter int DIGITS   = DEVICE_NUM_NUMLED_EN,
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int GUARD    = GUARD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num_in,
  input  logic                  num_we,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     led_en,
  output logic                  led_ca,
  output logic                  led_cb,
  output logic                  led_cc,
  output logic                  led_cd,
  output logic                  led_ce,
  output logic                  led_cf,
  output logic                  led_cg,
  output logic                  led_dp,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(SCAN_DIV - 2);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD);
  localparam logic [DW-1:0] DIG_MAX = DW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [DW-1:0]         dig;
  logic [4*DIGITS-1:0]   shadow_num, active_num, load_num;
  logic [DIGITS-1:0]     shadow_dp, active_dp;
  logic [DIGITS-1:0]     blank;
  logic                  tick, wrap, load;
  seg_t                  dec_seg, seg_q, seg_nx;
  logic [DIGITS-1:0]     en_nx;
  logic                  dp_nx;

  assign tick     = (cnt == CNT_MAX);
  assign wrap     = tick && (dig == DIG_MAX);
  assign load     = wrap && (num_we || pending);
  assign load_num = num_we ? num_in : shadow_num;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dig <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) dig <= (dig == DIG_MAX) ? '0 : dig + DW'(1);
    end
  end

  // A write landing on the wrap cycle bypasses the shadow so it is shown immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_num <= '0;
      shadow_dp  <= '0;
      active_num <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (num_we) begin
        shadow_num <= num_in;
        shadow_dp  <= dp_in;
      end
      if (load) begin
        active_num <= load_num;
        active_dp  <= num_we ? dp_in : shadow_dp;
      end
      pending <= wrap ? 1'b0 : (num_we | pending);
    end
  end

`ifdef NUMLED_LEADING_ZERO_BLANK_EN
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] v);
    logic still;
    lz_mask = '0;
    still   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (still && v[4*i +: 4] == 4'h0) lz_mask[i] = 1'b1;
      else                              still      = 1'b0;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       blank <= lz_mask('0);
    else if (load) blank <= lz_mask(load_num);
  end
`else
  assign blank = '0;
`endif

  numled_hex_decode u_dec (
    .nibble (active_num[{dig, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  // Blanked digits stay dark unless their DP is set, which lights the DP alone.
  always_comb begin
    en_nx  = '1;
    seg_nx = '1;
    dp_nx  = 1'b1;
    if (cnt >= CNT_GRD) begin
      dp_nx = ~active_dp[dig];
      if (!blank[dig]) begin
        en_nx  = ~(DIGITS'(1) << dig);
        seg_nx = dec_seg;
      end else if (active_dp[dig]) begin
        en_nx  = ~(DIGITS'(1) << dig);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_en     <= '1;
      seg_q      <= '1;
      led_dp     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      led_en     <= en_nx;
      seg_q      <= seg_nx;
      led_dp     <= dp_nx;
      frame_done <= (cnt == CNT_PRE) && (dig == DIG_MAX);
    end
  end

  assign {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca} = seg_q;

endmodule

// File: tb/tb_numled_scan_driver.sv
// Scoreboard bench for numled_scan_driver with SCAN_DIV=4, GUARD=1 (32-clock frames).
module tb_numled_scan_driver;

  typedef struct {
    logic [7:0] en;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] num_in = '0;
  logic        num_we = 1'b0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  led_en;
  logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
  logic        pending, frame_done;
  logic [6:0]  seg;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   last_fd = 0;
  bit   track = 1'b0;
  exp_t q[$];

  // Active-low codes {g..a}, written as the classic common-anode values.
  logic [6:0] segl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign seg = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

  numled_scan_driver #(.DIGITS(8), .SCAN_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst(rst), .num_in(num_in), .num_we(num_we), .dp_in(dp_in),
    .led_en(led_en), .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc),
    .led_cd(led_cd), .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg),
    .led_dp(led_dp), .pending(pending), .frame_done(frame_done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Expected lit cycles for one full frame showing val/dp: 3 lit clocks per digit.
  task automatic push_frame(input logic [31:0] val, input logic [7:0] dp);
    logic [7:0] bl;
    logic       still;
    exp_t       e;
    bl = '0;
    still = 1'b1;
`ifdef NUMLED_LEADING_ZERO_BLANK_EN
    for (int d = 7; d > 0; d--) begin
      if (still && val[4*d +: 4] == 4'h0) bl[d] = 1'b1;
      else                                still = 1'b0;
    end
`endif
    for (int d = 0; d < 8; d++) begin
      if (!(bl[d] && !dp[d])) begin
        for (int k = 0; k < 3; k++) begin
          e.en  = ~(8'h01 << d);
          e.seg = bl[d] ? 7'h7F : segl[val[4*d +: 4]];
          e.dp  = ~dp[d];
          q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (track && led_en !== 8'hFF) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scan_extra: got en=%h seg=%h dp=%b, expected no lit digit", led_en, seg, led_dp);
      end else begin
        e = q.pop_front();
        check("scan_en", {24'h0, led_en}, {24'h0, e.en});
        check("scan_seg", {25'h0, seg}, {25'h0, e.seg});
        check("scan_dp", {31'h0, led_dp}, {31'h0, e.dp});
      end
    end
  end

  task automatic wait_fd(input bit per_chk);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_done && k < 80);
    if (!frame_done) begin
      n_total++;
      $display("FAIL fd_timeout: got no frame_done in %0d clocks, expected one within 32", k);
    end else if (per_chk) begin
      check("fd_period", cyc - last_fd, 32);
    end
    last_fd = cyc;
  endtask

  task automatic fd_tail();
    @(negedge clk);
    check("fd_width", {31'h0, frame_done}, 0);
  endtask

  task automatic chk_dark(input string nm);
    check({nm, "_en"}, {24'h0, led_en}, 32'hFF);
    check({nm, "_seg"}, {25'h0, seg}, 32'h7F);
    check({nm, "_dp"}, {31'h0, led_dp}, 1);
    check({nm, "_pend"}, {31'h0, pending}, 0);
    check({nm, "_fd"}, {31'h0, frame_done}, 0);
  endtask

  task automatic write(input logic [31:0] v, input logic [7:0] dp);
    @(negedge clk);
    num_in = v;
    dp_in  = dp;
    num_we = 1'b1;
    @(negedge clk);
    num_we = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_dark("reset");
    push_frame(32'h0, 8'h00);
    rst = 1'b0;
    track = 1'b1;
    repeat (2) @(negedge clk);
    check("dig0_first", {24'h0, led_en}, 32'hFE);

    // Frame 1 shows 89ABCDEF with digit 0 DP
    write(32'h89ABCDEF, 8'h01);
    check("pend_rise", {31'h0, pending}, 1);
    push_frame(32'h89ABCDEF, 8'h01);
    wait_fd(1'b0);
    check("pend_hold", {31'h0, pending}, 1);
    fd_tail();
    check("pend_clr", {31'h0, pending}, 0);

    // Back-to-back writes: only the last reaches the display
    write(32'h1, 8'h00);
    repeat (3) @(negedge clk);
    write(32'h2, 8'h00);
    check("pend_b2b", {31'h0, pending}, 1);
    push_frame(32'h2, 8'h00);
    wait_fd(1'b1);
    fd_tail();
    check("pend_b2b_clr", {31'h0, pending}, 0);

    // Write coincident with frame_done bypasses the shadow
    wait_fd(1'b1);
    num_in = 32'h5;
    dp_in  = 8'h00;
    num_we = 1'b1;
    push_frame(32'h5, 8'h00);
    push_frame(32'h5, 8'h00);
    fd_tail();
    num_we = 1'b0;
    check("wrap_pend", {31'h0, pending}, 0);
    @(negedge clk);
    check("wrap_pend2", {31'h0, pending}, 0);
    wait_fd(1'b1);
    fd_tail();
    wait_fd(1'b1);
    fd_tail();
    #1 track = 1'b0;

    // Reset mid-slot discards a pending value
    repeat (5) @(negedge clk);
    write(32'hDEADBEEF, 8'hAA);
    check("pend_pre_rst", {31'h0, pending}, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_dark("mid_rst");
    @(negedge clk);
    push_frame(32'h0, 8'h00);
    rst = 1'b0;
    track = 1'b1;
    repeat (2) @(negedge clk);
    check("dig0_after_rst", {24'h0, led_en}, 32'hFE);

    write(32'h00000400, 8'h00);
    push_frame(32'h00000400, 8'h00);
    wait_fd(1'b0);
    fd_tail();
    wait_fd(1'b1);
    fd_tail();
    #1 track = 1'b0;
    repeat (4) @(negedge clk);
    check("scan_left", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
